dec_uop_queue: RTL and testbench
================================

Name: dec_uop_queue

Overview:
- Decoupling FIFO between the decode stage and the register-read (RR) pipeline latch.
- Buffers fully decoded 267-bit uop packets so decode keeps running while RR is stalled.
- Presents the head packet, with its valid bit, directly to the RR latch input.
- Discards all buffered uops on a pipeline invalidate (branch mispredict or flush).

Parameters:
- WIDTH, 267: decoded packet width. Bit 0 is the valid bit; bit layout matches the RR latch input.
- DEPTH, 4: number of queue entries. Must be a power of two and at least 2.
- PTR_W, 2: log2(DEPTH). Width of the read and write pointers.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- i_pkt  in  WIDTH  decoded uop packet from decode; i_pkt[0] is its valid bit.
- i_push  in  1  decode requests to enqueue i_pkt.
- o_full  out  1  queue full; used as the decode stall.
- o_pkt  out  WIDTH  head packet to the RR latch input.
- o_v  out  1  head entry valid; equals o_pkt[0].
- i_rr_stall  in  1  RR latch holding; the head is not consumed.
- i_flush  in  1  invalidate all buffered uops.
- o_count  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x WIDTH register array; wr_ptr and rd_ptr (PTR_W bits each) wrap modulo DEPTH; count is PTR_W+1 bits.
- Enqueue condition: push_ok = i_push & i_pkt[0] & ~o_full & ~i_flush.
  - A packet with bit 0 = 0 is never stored, even when i_push is 1.
- Dequeue condition: pop_ok = o_v & ~i_rr_stall & ~i_flush.
- Count update:
  - push_ok only: count+1.
  - pop_ok only: count-1.
  - Both: count unchanged, both pointers advance.
  - Neither: hold.
- Full boundary: o_full = (count == DEPTH), derived from registered state. A push while full is dropped even if a pop occurs in the same cycle; decode must hold the packet and retry.
- Empty boundary: o_v = (count != 0). When empty, o_pkt is all zeros, so RR latches a bubble.
- When not empty, o_pkt = mem[rd_ptr] with bit 0 forced to 1.
- Latency: a packet pushed in cycle N appears on o_pkt in cycle N+1 at the earliest (the DEC_Q_BYPASS_EN feature changes this).
- Ordering: strict FIFO; no reordering or coalescing.
- Flush: i_flush has priority over push and pop.
  - On the next edge: wr_ptr = rd_ptr = 0, count = 0.
  - Any push in the flush cycle is discarded.
  - o_v is 0 from the cycle after the flush.
  - Memory contents are not cleared; they are masked by count.
- Stall during flush: i_flush wins; the queue empties regardless of i_rr_stall.
- Reset (rst = 0, asynchronous): pointers = 0, count = 0, hence o_v = 0, o_full = 0, o_pkt = 0.
  - Reset mid-operation drops all entries immediately, without waiting for a clock edge.
  - Memory array is not reset.
- Pointer wrap: a write at index DEPTH-1 wraps to 0; a full/empty decision never uses pointer equality, only count.

Optional Feature:
- Macro DEC_Q_BYPASS_EN.
- Defined: when count == 0 and push_ok, o_pkt = i_pkt and o_v = 1 combinationally in the same cycle.
  - If i_rr_stall = 0 that cycle, the packet is consumed directly and not written; count stays 0.
  - If stalled, the packet is written as usual.
- Not defined: no combinational path from i_pkt to o_pkt; minimum latency is 1 cycle.

Decomposition:
- Shared package (dec_rr_pkg), holding:
  - DEC_PKT_W = 267.
  - Field offset constants for the packet: V = 0, BRFID = 4:1, DFLAG = 5, INDIR = 6, BPTAKEN = 7, SEGR2 = 10:8, SEGR1 = 13:11, IDX = 16:14, BASE = 19:17, SR2 = 22:20, SR1 = 25:23, OPSIZE = 27:26, IMM8 = 35:28, BPTGT = 67:36, EIP = 99:68, NEIP = 131:100, CS = 266:205.
  - DEC_Q_DEPTH default.
- One natural sub-module, uq_ptr_ctl: pointer and count update plus full/empty generation. The data array stays in the top level.

Test Plan:
- Reset, then push 4 packets whose EIP fields are 0x1000, 0x1004, 0x1008, 0x100C with i_rr_stall = 1 -> o_count = 4, o_full = 1, o_pkt EIP = 0x1000; a 5th push is dropped and count stays 4.
- From full, release the stall for 4 cycles -> o_pkt EIP sequence 0x1000, 0x1004, 0x1008, 0x100C, then o_v = 0 and o_pkt = 0.
- Push and pop simultaneously every cycle for 10 cycles starting at count = 2 -> count holds at 2, pointers wrap, order preserved.
- With count = 3 and i_flush = 1 together with i_push = 1 -> next cycle count = 0, o_v = 0; the flushed-cycle packet never appears.
- Assert rst low between edges while count = 3 -> o_v = 0 and o_count = 0 immediately; after release, the first push appears 1 cycle later (or the same cycle with DEC_Q_BYPASS_EN).
- i_push = 1 with i_pkt[0] = 0 -> not stored, count unchanged; with DEC_Q_BYPASS_EN and an empty queue, a valid push with no stall gives o_v = 1 in the same cycle and count stays 0.

Source files
------------

// File: rtl/dec_rr_pkg.sv
// Shared decode -> register-read definitions: packet width, field offsets and
// default uop queue depth.
package dec_rr_pkg;

  localparam int unsigned DEC_PKT_W   = 267;
  localparam int unsigned DEC_Q_DEPTH = 4;

  // Decoded packet field offsets (bit layout matches the RR latch input).
  localparam int unsigned PKT_V          = 0;
  localparam int unsigned PKT_BRFID_LSB  = 1;
  localparam int unsigned PKT_BRFID_MSB  = 4;
  localparam int unsigned PKT_DFLAG      = 5;
  localparam int unsigned PKT_INDIR      = 6;
  localparam int unsigned PKT_BPTAKEN    = 7;
  localparam int unsigned PKT_SEGR2_LSB  = 8;
  localparam int unsigned PKT_SEGR2_MSB  = 10;
  localparam int unsigned PKT_SEGR1_LSB  = 11;
  localparam int unsigned PKT_SEGR1_MSB  = 13;
  localparam int unsigned PKT_IDX_LSB    = 14;
  localparam int unsigned PKT_IDX_MSB    = 16;
  localparam int unsigned PKT_BASE_LSB   = 17;
  localparam int unsigned PKT_BASE_MSB   = 19;
  localparam int unsigned PKT_SR2_LSB    = 20;
  localparam int unsigned PKT_SR2_MSB    = 22;
  localparam int unsigned PKT_SR1_LSB    = 23;
  localparam int unsigned PKT_SR1_MSB    = 25;
  localparam int unsigned PKT_OPSIZE_LSB = 26;
  localparam int unsigned PKT_OPSIZE_MSB = 27;
  localparam int unsigned PKT_IMM8_LSB   = 28;
  localparam int unsigned PKT_IMM8_MSB   = 35;
  localparam int unsigned PKT_BPTGT_LSB  = 36;
  localparam int unsigned PKT_BPTGT_MSB  = 67;
  localparam int unsigned PKT_EIP_LSB    = 68;
  localparam int unsigned PKT_EIP_MSB    = 99;
  localparam int unsigned PKT_NEIP_LSB   = 100;
  localparam int unsigned PKT_NEIP_MSB   = 131;
  localparam int unsigned PKT_CS_LSB     = 205;
  localparam int unsigned PKT_CS_MSB     = 266;

  typedef logic [DEC_PKT_W-1:0] dec_pkt_t;

  // Extract the instruction pointer of a decoded packet.
  function automatic logic [31:0] pkt_eip(input dec_pkt_t pkt);
    return pkt[PKT_EIP_MSB:PKT_EIP_LSB];
  endfunction

endpackage

// File: rtl/uq_ptr_ctl.sv
// Uop queue pointer/count control: read and write pointers that wrap modulo
// DEPTH, occupancy count, and full/empty flags derived only from the count.
module uq_ptr_ctl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             flush,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [PTR_W:0]   count_d, count_q;

  // Next-state: flush empties the queue; otherwise advance on accepted ops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Flags from the count only; pointer equality is ambiguous when full/empty.
  always_comb begin
    wr_ptr = wr_ptr_q;
    rd_ptr = rd_ptr_q;
    count  = count_q;
    full   = (count_q == (PTR_W+1)'(DEPTH));
    empty  = (count_q == '0);
  end

endmodule

// File: rtl/dec_uop_queue.sv
// Decode -> RR decoupling FIFO for decoded uop packets. The head packet is
// presented straight to the RR latch input; an empty queue presents zeros.
// Optional macro DEC_Q_BYPASS_EN: an empty queue forwards a valid push to
// o_pkt combinationally and, if RR is not stalled, consumes it unwritten.
module dec_uop_queue
  import dec_rr_pkg::*;
#(
  parameter int unsigned WIDTH = DEC_PKT_W,
  parameter int unsigned DEPTH = DEC_Q_DEPTH,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_pkt,
  input  logic             i_push,
  output logic             o_full,
  output logic [WIDTH-1:0] o_pkt,
  output logic             o_v,
  input  logic             i_rr_stall,
  input  logic             i_flush,
  output logic [PTR_W:0]   o_count
);

  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty;
  logic             push_ok, wr_en, rd_en;
  logic [WIDTH-1:0] head_pkt;

  uq_ptr_ctl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr_ctl (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .flush  (i_flush),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Accept/consume decisions and head presentation.
  always_comb begin
    // Invalid packets are never stored; a push while full is dropped even
    // if the head pops this cycle, since full comes from registered state.
    push_ok     = i_push & i_pkt[PKT_V] & ~full & ~i_flush;
    rd_en       = ~empty & ~i_rr_stall & ~i_flush;
    head_pkt    = mem_q[rd_ptr];
    head_pkt[0] = 1'b1;
`ifdef DEC_Q_BYPASS_EN
    if (empty && push_ok) begin
      o_pkt = i_pkt;
      o_v   = 1'b1;
      // RR takes the packet directly; only buffer it if RR is holding.
      wr_en = i_rr_stall;
    end else begin
      o_pkt = empty ? '0 : head_pkt;
      o_v   = ~empty;
      wr_en = push_ok;
    end
`else
    o_pkt = empty ? '0 : head_pkt;
    o_v   = ~empty;
    wr_en = push_ok;
`endif
    o_full  = full;
    o_count = count;
  end

  // Storage write; contents are left stale on flush/reset, masked by count.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = mem_q[i];
    if (wr_en) mem_d[wr_ptr] = i_pkt;
  end

  // Data array: no reset needed since unread entries are never presented.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
  end

endmodule

// File: tb/tb_dec_uop_queue.sv
// Directed self-checking bench for dec_uop_queue (default and bypass builds).
module tb_dec_uop_queue;
  import dec_rr_pkg::*;

  localparam int unsigned W  = DEC_PKT_W;
  localparam int unsigned PW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  i_pkt;
  logic          i_push;
  logic          o_full;
  logic [W-1:0]  o_pkt;
  logic          o_v;
  logic          i_rr_stall;
  logic          i_flush;
  logic [PW:0]   o_count;

  int total = 0;
  int bad   = 0;

  dec_uop_queue #(
    .WIDTH (W),
    .DEPTH (4),
    .PTR_W (PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_pkt      (i_pkt),
    .i_push     (i_push),
    .o_full     (o_full),
    .o_pkt      (o_pkt),
    .o_v        (o_v),
    .i_rr_stall (i_rr_stall),
    .i_flush    (i_flush),
    .o_count    (o_count)
  );

  always #5 clk = ~clk;

  // Build a valid packet carrying eip in EIP and a tag in CS/NEIP so the
  // whole width is exercised.
  function automatic logic [W-1:0] mk(input logic [31:0] eip);
    logic [W-1:0] p;
    p = '0;
    p[PKT_EIP_MSB:PKT_EIP_LSB]   = eip;
    p[PKT_NEIP_MSB:PKT_NEIP_LSB] = eip + 32'd4;
    p[PKT_CS_MSB:PKT_CS_LSB]     = {30'h2aaa_5555, eip};
    p[PKT_IMM8_MSB:PKT_IMM8_LSB] = eip[7:0] ^ 8'h5a;
    p[PKT_V] = 1'b1;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] p;
    rst        = 1'b0;
    i_pkt      = '0;
    i_push     = 1'b0;
    i_rr_stall = 1'b0;
    i_flush    = 1'b0;

    // Reset state
    #12;
    chk("rst_v", W'(o_v), W'(0));
    chk("rst_full", W'(o_full), W'(0));
    chk("rst_count", W'(o_count), W'(0));
    chk("rst_pkt", o_pkt, '0);
    rst = 1'b1;
    tick();

    // Fill with RR stalled
    i_rr_stall = 1'b1;
    i_push     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_pkt = mk(32'h1000 + 32'(4 * i));
      tick();
      chk("fill_count", W'(o_count), W'(i + 1));
    end
    chk("fill_full", W'(o_full), W'(1));
    chk("fill_head", o_pkt, mk(32'h1000));
    i_pkt = mk(32'h2000);
    tick();
    chk("drop5_count", W'(o_count), W'(4));
    chk("drop5_head", o_pkt, mk(32'h1000));

    // Drain; the first drain cycle also pushes, which must be dropped
    i_rr_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", o_pkt, mk(32'h1000 + 32'(4 * i)));
      tick();
      i_push = 1'b0;
      chk("drain_count", W'(o_count), W'(3 - i));
    end
    chk("empty_v", W'(o_v), W'(0));
    chk("empty_pkt", o_pkt, '0);
    chk("empty_full", W'(o_full), W'(0));

    // Steady push+pop at count 2 across pointer wrap
    i_rr_stall = 1'b1;
    i_push     = 1'b1;
    i_pkt      = mk(32'h3000);
    tick();
    i_pkt = mk(32'h3004);
    tick();
    chk("pp_start", W'(o_count), W'(2));
    i_rr_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      i_pkt = mk(32'h3008 + 32'(4 * i));
      chk("pp_head", o_pkt, mk(32'h3000 + 32'(4 * i)));
      tick();
      chk("pp_count", W'(o_count), W'(2));
    end
    chk("pp_last", o_pkt, mk(32'h3028));

    // Flush at count 3 with a push and a stall in the same cycle
    i_rr_stall = 1'b1;
    i_pkt      = mk(32'h302c);
    tick();
    chk("pre_flush", W'(o_count), W'(3));
    i_flush = 1'b1;
    i_pkt   = mk(32'h4000);
    tick();
    i_flush = 1'b0;
    i_push  = 1'b0;
    chk("flush_count", W'(o_count), W'(0));
    chk("flush_v", W'(o_v), W'(0));
    chk("flush_pkt", o_pkt, '0);
    i_push = 1'b1;
    i_pkt  = mk(32'h5000);
    tick();
    chk("post_flush_head", o_pkt, mk(32'h5000));
    chk("post_flush_cnt", W'(o_count), W'(1));

    // Asynchronous reset mid-cycle at count 3
    i_pkt = mk(32'h5004);
    tick();
    i_pkt = mk(32'h5008);
    tick();
    i_push = 1'b0;
    chk("pre_rst", W'(o_count), W'(3));
    #2;
    rst = 1'b0;
    #1;
    chk("arst_v", W'(o_v), W'(0));
    chk("arst_count", W'(o_count), W'(0));
    chk("arst_pkt", o_pkt, '0);
    #1;
    rst    = 1'b1;
    i_push = 1'b1;
    i_pkt  = mk(32'h6000);
    #1;
`ifdef DEC_Q_BYPASS_EN
    chk("rst_push_same", o_pkt, mk(32'h6000));
`else
    chk("rst_push_same", o_pkt, '0);
`endif
    tick();
    chk("rst_push_next", o_pkt, mk(32'h6000));
    chk("rst_push_cnt", W'(o_count), W'(1));

    // Invalid packet is never stored
    p    = mk(32'h7000);
    p[0] = 1'b0;
    i_pkt = p;
    tick();
    chk("inv_count", W'(o_count), W'(1));
    chk("inv_head", o_pkt, mk(32'h6000));
    i_push     = 1'b0;
    i_rr_stall = 1'b0;
    tick();
    chk("inv_drain", W'(o_count), W'(0));

    // Valid push into an empty queue with no stall
    i_push = 1'b1;
    i_pkt  = mk(32'h8000);
    #1;
`ifdef DEC_Q_BYPASS_EN
    chk("byp_v", W'(o_v), W'(1));
    chk("byp_pkt", o_pkt, mk(32'h8000));
    tick();
    i_push = 1'b0;
    chk("byp_count", W'(o_count), W'(0));
`else
    chk("nobyp_v", W'(o_v), W'(0));
    tick();
    i_push = 1'b0;
    chk("nobyp_count", W'(o_count), W'(1));
    chk("nobyp_pkt", o_pkt, mk(32'h8000));
    chk("nobyp_eip", W'(pkt_eip(o_pkt)), W'(32'h8000));
    tick();
    chk("nobyp_drain", W'(o_count), W'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
